// File: rtl/glb_fifo_arbiter.sv
// Arbitrates ifmap/ipsum read FIFOs and opsum write FIFOs onto a single-port GLB.
// Class priority is opsum > ipsum > ifmap.
// Optional macro GLB_ARB_ROUND_ROBIN_EN selects the within-class policy:
//   defined   -> per-class rotating pointer
//   undefined -> lowest requesting index wins
module glb_fifo_arbiter #(
    parameter int unsigned NUM_CH = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ifmap_read_req_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ifmap_glb_read_addr_matrix_i,
    input  logic [NUM_CH-1:0]          ipsum_read_req_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0]   ipsum_glb_read_addr_matrix_i,
    input  logic [NUM_CH-1:0]          opsum_glb_write_req_matrix_i,
    input  logic [NUM_CH*ADDR_W-1:0]   opsum_glb_write_addr_matrix_i,
    input  logic [NUM_CH*4-1:0]        opsum_glb_write_web_matrix_i,
    input  logic [NUM_CH*32-1:0]       opsum_fifo_pop_data_matrix_i,
    input  logic [31:0]                glb_rdata_i,
    output logic [NUM_CH-1:0]          ifmap_permit_push_matrix_o,
    output logic [NUM_CH-1:0]          ipsum_permit_push_matrix_o,
    output logic [NUM_CH-1:0]          opsum_permit_pop_matrix_o,
    output logic [31:0]                ifmap_glb_read_data_o,
    output logic [31:0]                ipsum_glb_read_data_o,
    output logic                       fifo_glb_busy_o,
    output logic                       glb_en_o,
    output logic [3:0]                 glb_web_o,
    output logic [ADDR_W-1:0]          glb_addr_o,
    output logic [31:0]                glb_wdata_o
);

    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WEB_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CLS_IFMAP = 2'd0,
        CLS_IPSUM = 2'd1,
        CLS_OPSUM = 2'd2
    } cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [ADDR_W-1:0]  ifmap_addr_a [NUM_CH];
    logic [ADDR_W-1:0]  ipsum_addr_a [NUM_CH];
    logic [ADDR_W-1:0]  opsum_addr_a [NUM_CH];
    logic [WEB_W-1:0]   opsum_web_a  [NUM_CH];
    logic [DATA_W-1:0]  opsum_data_a [NUM_CH];

    logic               if_found, ip_found, op_found;
    logic [IDX_W-1:0]   if_idx, ip_idx, op_idx;

    // Split the flattened per-channel buses into indexable arrays
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ifmap_addr_a[g] = ifmap_glb_read_addr_matrix_i[g*ADDR_W +: ADDR_W];
        assign ipsum_addr_a[g] = ipsum_glb_read_addr_matrix_i[g*ADDR_W +: ADDR_W];
        assign opsum_addr_a[g] = opsum_glb_write_addr_matrix_i[g*ADDR_W +: ADDR_W];
        assign opsum_web_a[g]  = opsum_glb_write_web_matrix_i[g*WEB_W +: WEB_W];
        assign opsum_data_a[g] = opsum_fifo_pop_data_matrix_i[g*DATA_W +: DATA_W];
    end

    // First set request at or after ptr, ascending with wrap; returns {found, index}
    function automatic logic [IDX_W:0] pick(input logic [NUM_CH-1:0] req,
                                            input logic [IDX_W-1:0]  ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      pos;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pos = (32'(ptr) + i) % NUM_CH;
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
        return {found, idx};
    endfunction

    // Index following k, wrapping the last channel back to 0
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        return (k == IDX_W'(NUM_CH - 1)) ? '0 : k + IDX_W'(1);
    endfunction

`ifdef GLB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] if_ptr_q, if_ptr_d;
    logic [IDX_W-1:0] ip_ptr_q, ip_ptr_d;
    logic [IDX_W-1:0] op_ptr_q, op_ptr_d;

    // Per-class rotating pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ptr_q <= '0;
            ip_ptr_q <= '0;
            op_ptr_q <= '0;
        end else begin
            if_ptr_q <= if_ptr_d;
            ip_ptr_q <= ip_ptr_d;
            op_ptr_q <= op_ptr_d;
        end
    end

    // Candidate per class, searched from its pointer
    always_comb begin
        {if_found, if_idx} = pick(ifmap_read_req_matrix_i,      if_ptr_q);
        {ip_found, ip_idx} = pick(ipsum_read_req_matrix_i,      ip_ptr_q);
        {op_found, op_idx} = pick(opsum_glb_write_req_matrix_i, op_ptr_q);
    end

    // Advance only the pointer of the class granted this cycle
    always_comb begin
        if_ptr_d = if_ptr_q;
        ip_ptr_d = ip_ptr_q;
        op_ptr_d = op_ptr_q;
        if (state_q == ST_IDLE) begin
            if (op_found) begin
                op_ptr_d = next_idx(op_idx);
            end else if (ip_found) begin
                ip_ptr_d = next_idx(ip_idx);
            end else if (if_found) begin
                if_ptr_d = next_idx(if_idx);
            end
        end
    end
`else
    // Candidate per class, lowest requesting index
    always_comb begin
        {if_found, if_idx} = pick(ifmap_read_req_matrix_i,      IDX_W'(0));
        {ip_found, ip_idx} = pick(ipsum_read_req_matrix_i,      IDX_W'(0));
        {op_found, op_idx} = pick(opsum_glb_write_req_matrix_i, IDX_W'(0));
    end
`endif

    // State and winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_IFMAP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and outputs, decoded from the registered state and winner
    always_comb begin
        state_d                    = state_q;
        cls_d                      = cls_q;
        idx_d                      = idx_q;
        ifmap_permit_push_matrix_o = '0;
        ipsum_permit_push_matrix_o = '0;
        opsum_permit_pop_matrix_o  = '0;
        ifmap_glb_read_data_o      = '0;
        ipsum_glb_read_data_o      = '0;
        fifo_glb_busy_o            = 1'b0;
        glb_en_o                   = 1'b0;
        glb_web_o                  = 4'hF;
        glb_addr_o                 = '0;
        glb_wdata_o                = '0;

        case (state_q)
            ST_IDLE: begin
                if (op_found) begin
                    cls_d   = CLS_OPSUM;
                    idx_d   = op_idx;
                    state_d = ST_ACCESS;
                end else if (ip_found) begin
                    cls_d   = CLS_IPSUM;
                    idx_d   = ip_idx;
                    state_d = ST_ACCESS;
                end else if (if_found) begin
                    cls_d   = CLS_IFMAP;
                    idx_d   = if_idx;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                fifo_glb_busy_o = 1'b1;
                glb_en_o        = 1'b1;
                if (cls_q == CLS_OPSUM) begin
                    glb_addr_o                = opsum_addr_a[idx_q];
                    glb_web_o                 = opsum_web_a[idx_q];
                    glb_wdata_o               = opsum_data_a[idx_q];
                    opsum_permit_pop_matrix_o = NUM_CH'(1) << idx_q;
                    state_d                   = ST_IDLE;
                end else begin
                    glb_addr_o = (cls_q == CLS_IPSUM) ? ipsum_addr_a[idx_q]
                                                      : ifmap_addr_a[idx_q];
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                fifo_glb_busy_o       = 1'b1;
                ifmap_glb_read_data_o = glb_rdata_i;
                ipsum_glb_read_data_o = glb_rdata_i;
                if (cls_q == CLS_IPSUM) begin
                    ipsum_permit_push_matrix_o = NUM_CH'(1) << idx_q;
                end else if (cls_q == CLS_IFMAP) begin
                    ifmap_permit_push_matrix_o = NUM_CH'(1) << idx_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_glb_fifo_arbiter.sv
// Directed bench for glb_fifo_arbiter: write, read, class priority,
// within-class policy (both builds of GLB_ARB_ROUND_ROBIN_EN), reset mid-read,
// and requests that drop or arrive while a transaction is in flight.
module tb_glb_fifo_arbiter;

    localparam int unsigned NUM_CH = 32;
    localparam int unsigned ADDR_W = 32;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_CH-1:0]         ifmap_req;
    logic [NUM_CH*ADDR_W-1:0]  ifmap_addr;
    logic [NUM_CH-1:0]         ipsum_req;
    logic [NUM_CH*ADDR_W-1:0]  ipsum_addr;
    logic [NUM_CH-1:0]         opsum_req;
    logic [NUM_CH*ADDR_W-1:0]  opsum_addr;
    logic [NUM_CH*4-1:0]       opsum_web;
    logic [NUM_CH*32-1:0]      opsum_data;
    logic [31:0]               glb_rdata;
    logic [NUM_CH-1:0]         ifmap_push;
    logic [NUM_CH-1:0]         ipsum_push;
    logic [NUM_CH-1:0]         opsum_pop;
    logic [31:0]               ifmap_rd;
    logic [31:0]               ipsum_rd;
    logic                      busy;
    logic                      glb_en;
    logic [3:0]                glb_web;
    logic [ADDR_W-1:0]         glb_addr;
    logic [31:0]               glb_wdata;

    int n_checks;
    int n_errors;

    glb_fifo_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .ifmap_read_req_matrix_i       (ifmap_req),
        .ifmap_glb_read_addr_matrix_i  (ifmap_addr),
        .ipsum_read_req_matrix_i       (ipsum_req),
        .ipsum_glb_read_addr_matrix_i  (ipsum_addr),
        .opsum_glb_write_req_matrix_i  (opsum_req),
        .opsum_glb_write_addr_matrix_i (opsum_addr),
        .opsum_glb_write_web_matrix_i  (opsum_web),
        .opsum_fifo_pop_data_matrix_i  (opsum_data),
        .glb_rdata_i                   (glb_rdata),
        .ifmap_permit_push_matrix_o    (ifmap_push),
        .ipsum_permit_push_matrix_o    (ipsum_push),
        .opsum_permit_pop_matrix_o     (opsum_pop),
        .ifmap_glb_read_data_o         (ifmap_rd),
        .ipsum_glb_read_data_o         (ipsum_rd),
        .fifo_glb_busy_o               (busy),
        .glb_en_o                      (glb_en),
        .glb_web_o                     (glb_web),
        .glb_addr_o                    (glb_addr),
        .glb_wdata_o                   (glb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output at its reset/idle value
    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(busy),       64'h0);
        check({tag, "_en"},    64'(glb_en),     64'h0);
        check({tag, "_web"},   64'(glb_web),    64'hF);
        check({tag, "_addr"},  64'(glb_addr),   64'h0);
        check({tag, "_wdata"}, 64'(glb_wdata),  64'h0);
        check({tag, "_ifp"},   64'(ifmap_push), 64'h0);
        check({tag, "_ipp"},   64'(ipsum_push), 64'h0);
        check({tag, "_opp"},   64'(opsum_pop),  64'h0);
        check({tag, "_ifrd"},  64'(ifmap_rd),   64'h0);
        check({tag, "_iprd"},  64'(ipsum_rd),   64'h0);
    endtask

    logic [4:0]  rr_exp_idx [3];
    logic [31:0] rr_exp_addr;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        ifmap_req  = '0;
        ipsum_req  = '0;
        opsum_req  = '0;
        ifmap_addr = '0;
        ipsum_addr = '0;
        opsum_addr = '0;
        opsum_web  = '1;
        opsum_data = '0;
        glb_rdata  = 32'hCAFEF00D;

        // Reset values, and idle with no request
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_idle("noreq");

        // Write: opsum channel 3
        opsum_req[3]                = 1'b1;
        opsum_addr[3*ADDR_W +: ADDR_W] = 32'h40;
        opsum_web[3*4 +: 4]         = 4'h0;
        opsum_data[3*32 +: 32]      = 32'hDEADBEEF;
        tick();
        check("wr_en",    64'(glb_en),    64'h1);
        check("wr_addr",  64'(glb_addr),  64'h40);
        check("wr_web",   64'(glb_web),   64'h0);
        check("wr_wdata", 64'(glb_wdata), 64'hDEADBEEF);
        check("wr_pop",   64'(opsum_pop), 64'h8);
        check("wr_busy",  64'(busy),      64'h1);
        opsum_req[3] = 1'b0;
        tick();
        check_idle("wr_done");

        // Read: ifmap channel 5
        ifmap_req[5]                   = 1'b1;
        ifmap_addr[5*ADDR_W +: ADDR_W] = 32'h100;
        tick();
        check("rd_acc_en",   64'(glb_en),     64'h1);
        check("rd_acc_web",  64'(glb_web),    64'hF);
        check("rd_acc_addr", 64'(glb_addr),   64'h100);
        check("rd_acc_rd",   64'(ifmap_rd),   64'h0);
        check("rd_acc_push", 64'(ifmap_push), 64'h0);
        ifmap_req[5] = 1'b0;
        glb_rdata    = 32'h12345678;
        tick();
        check("rd_resp_push",  64'(ifmap_push), 64'h20);
        check("rd_resp_ifrd",  64'(ifmap_rd),   64'h12345678);
        check("rd_resp_iprd",  64'(ipsum_rd),   64'h12345678);
        check("rd_resp_en",    64'(glb_en),     64'h0);
        check("rd_resp_busy",  64'(busy),       64'h1);
        check("rd_resp_ipp",   64'(ipsum_push), 64'h0);
        tick();
        check_idle("rd_done");

        // Class priority: all three classes on channel 0 together
        opsum_addr[0 +: ADDR_W] = 32'h10;
        ipsum_addr[0 +: ADDR_W] = 32'h20;
        ifmap_addr[0 +: ADDR_W] = 32'h30;
        opsum_web[0 +: 4]       = 4'h3;
        opsum_data[0 +: 32]     = 32'h11112222;
        opsum_req[0] = 1'b1;
        ipsum_req[0] = 1'b1;
        ifmap_req[0] = 1'b1;
        tick();
        check("pri1_pop",  64'(opsum_pop), 64'h1);
        check("pri1_addr", 64'(glb_addr),  64'h10);
        check("pri1_web",  64'(glb_web),   64'h3);
        opsum_req[0] = 1'b0;
        tick();
        check("pri1_idle", 64'(busy), 64'h0);
        tick();
        check("pri2_addr", 64'(glb_addr),  64'h20);
        check("pri2_web",  64'(glb_web),   64'hF);
        ipsum_req[0] = 1'b0;
        tick();
        check("pri2_ipp",  64'(ipsum_push), 64'h1);
        check("pri2_ifp",  64'(ifmap_push), 64'h0);
        tick();
        tick();
        check("pri3_addr", 64'(glb_addr), 64'h30);
        ifmap_req[0] = 1'b0;
        tick();
        check("pri3_ifp",  64'(ifmap_push), 64'h1);
        tick();
        check_idle("pri_done");

        // Reset in RESP of an ipsum read; a request held through reset is taken first
        ipsum_req[2]                   = 1'b1;
        ipsum_addr[2*ADDR_W +: ADDR_W] = 32'h200;
        tick();
        ipsum_req[2] = 1'b0;
        tick();
        check("rst_pre_ipp", 64'(ipsum_push), 64'h4);
        rst_n                          = 1'b0;
        ipsum_req[7]                   = 1'b1;
        ipsum_addr[7*ADDR_W +: ADDR_W] = 32'h700;
        #1;
        check_idle("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_first_busy", 64'(busy),     64'h1);
        check("rst_first_addr", 64'(glb_addr), 64'h700);
        ipsum_req[7] = 1'b0;
        tick();
        check("rst_first_ipp", 64'(ipsum_push), 64'h80);
        tick();
        check_idle("rst_done");

        // Within-class policy from a freshly reset pointer
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`ifdef GLB_ARB_ROUND_ROBIN_EN
        rr_exp_idx[0] = 5'd0;
        rr_exp_idx[1] = 5'd31;
        rr_exp_idx[2] = 5'd0;
`else
        rr_exp_idx[0] = 5'd0;
        rr_exp_idx[1] = 5'd0;
        rr_exp_idx[2] = 5'd0;
`endif
        ipsum_addr[0 +: ADDR_W]         = 32'hA0;
        ipsum_addr[31*ADDR_W +: ADDR_W] = 32'hBF0;
        ipsum_req[0]  = 1'b1;
        ipsum_req[31] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rr_exp_addr = (rr_exp_idx[n] == 5'd31) ? 32'hBF0 : 32'hA0;
            tick();
            check($sformatf("rr%0d_addr", n), 64'(glb_addr), 64'(rr_exp_addr));
            tick();
            check($sformatf("rr%0d_ipp", n), 64'(ipsum_push), 64'(32'h1 << rr_exp_idx[n]));
            tick();
        end
        ipsum_req = '0;
        tick();
        tick();
        tick();
        check_idle("rr_done");

        // Request dropped in ACCESS completes; request raised in RESP waits for IDLE
        ifmap_req[9]                   = 1'b1;
        ifmap_addr[9*ADDR_W +: ADDR_W] = 32'h900;
        tick();
        check("late_acc_addr", 64'(glb_addr), 64'h900);
        ifmap_req[9] = 1'b0;
        tick();
        check("late_resp_ifp", 64'(ifmap_push), 64'h200);
        opsum_req[1]                   = 1'b1;
        opsum_addr[1*ADDR_W +: ADDR_W] = 32'h44;
        opsum_web[1*4 +: 4]            = 4'h5;
        opsum_data[1*32 +: 32]         = 32'h55AA55AA;
        tick();
        check("late_idle_busy", 64'(busy),      64'h0);
        check("late_idle_pop",  64'(opsum_pop), 64'h0);
        tick();
        check("late_wr_pop",   64'(opsum_pop), 64'h2);
        check("late_wr_addr",  64'(glb_addr),  64'h44);
        check("late_wr_web",   64'(glb_web),   64'h5);
        check("late_wr_wdata", 64'(glb_wdata), 64'h55AA55AA);
        opsum_req[1] = 1'b0;
        tick();
        check_idle("late_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
